mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Two-master arbiter and bus sequencer for the shared ROM/RAM bus (13-bit address, 8-bit data, rd/wr strobes).
- Master 0 is the CPU core.
- Master 1 is the program/data loader, which replaces bench-side memory preloading and also serves debug peeks/pokes.
- Grants one master per transaction and generates SETUP/ACCESS/DONE bus timing.
- Drives addr, rd, wr and the data-out enable toward addr_decode, rom and ram; the top-level instantiates the data-bus tristate.

Parameters:
AW, 13, address width
DW, 8, data width
WAIT_CYCLES, 2, cycles rd/wr held asserted (legal 1..15; 0 is treated as 1)
FIXED_PRI, 0, 0 = round-robin, 1 = m0 always wins, 2 = m1 always wins

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
m0_req  in  1  CPU transaction request
m0_we  in  1  1 = write, 0 = read
m0_addr  in  AW  CPU address
m0_wdata  in  DW  CPU write data
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  DW  read data, valid while m0_ack=1
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0, for the loader
addr  out  AW  bus address
rd  out  1  bus read strobe
wr  out  1  bus write strobe
bus_dout  out  DW  write data to bus
bus_oe  out  1  enable for bus_dout onto the shared data bus
bus_din  in  DW  data returned from the bus
owner  out  1  current or last grant (0 = m0, 1 = m1)

Behaviour:
- State machine states:
  - IDLE: arbitrate on the registered req inputs; if any req is high, latch the winner's we/addr/wdata into internal registers, set owner, go to SETUP.
  - SETUP (1 cycle): addr = latched address; rd = wr = 0; bus_oe = we.
  - ACCESS (WAIT_CYCLES cycles, counted by a 4-bit counter): rd = !we, wr = we, bus_oe = we, addr held.
    - On the last ACCESS cycle, for reads, capture bus_din into the winner's rdata register.
  - DONE (1 cycle): rd = wr = bus_oe = 0, addr held; winner's ack = 1. Next state is IDLE.
- Latency: req sampled high in IDLE at edge n gives ack high during cycle n+WAIT_CYCLES+2. Throughput is one transaction per WAIT_CYCLES+3 cycles.
- Requester rules:
  - Hold req, we, addr and wdata until ack.
  - Inputs are latched at grant, so later changes have no effect on the transaction in flight.
  - Dropping req mid-transaction does not abort it; ack still pulses.
  - Req held high after ack is a new request and is arbitrated in the next IDLE cycle.
- Arbitration:
  - Round-robin: if both req are high, grant the master that is not `owner`. A single requester always wins.
  - Fixed priority overrides the round-robin rule per FIXED_PRI.
- rd and wr are never both 1.
- bus_oe = 0 whenever rd = 1.
- ack goes only to the owner; the other master's ack stays 0.
- rdata retains its last value after ack. rdata is not updated on writes.
- addr holds its last value in IDLE.
- Reset (synchronous, any state, including mid-ACCESS):
  - State = IDLE; counter = 0.
  - addr = 0; rd = wr = bus_oe = 0; bus_dout = 0.
  - m0_ack = m1_ack = 0; m0_rdata = m1_rdata = 0.
  - owner = 1, so m0 wins the first contention.
  - A transaction aborted by reset produces no ack.

Optional Feature:
MEM_BUS_ARBITER_LOCK_EN
- With the macro defined:
  - Extra input port `m1_lock` (1 bit).
  - When owner = 1 and m1_lock = 1 in IDLE, m0 is not granted. m1 is granted if it requests; otherwise the arbiter stays IDLE.
  - This lets the loader stall the CPU across a multi-byte image load.
  - Lock is ignored when owner = 0; m1 must first win normally.
- Without the macro: port absent, plain arbitration only.

Test Plan:
- Reset mid-ACCESS: assert rst for 1 cycle during a write -> next cycle all outputs 0, no ack, owner = 1.
- m0 read, addr 0x1FFE, bus_din = 0xA5, WAIT_CYCLES = 2, req at edge n:
  - SETUP at n+1; rd = 1 at n+2..n+3.
  - m0_ack = 1 with m0_rdata = 0xA5 at n+4.
  - wr and bus_oe stay 0 throughout.
- m1 write, addr 0x0042, wdata 0x3C:
  - bus_oe = 1 for SETUP+ACCESS; wr = 1 for 2 cycles; bus_dout = 0x3C.
  - m1_ack at n+4; m1_rdata unchanged.
- Both req held high continuously for 4 transactions -> grants m0, m1, m0, m1; each ack 1 cycle; gaps 5 cycles.
- Change m0_addr from 0x0010 to 0x0020 during ACCESS; drop m0_req in SETUP -> bus addr stays 0x0010 and the ack still pulses.
- LOCK_EN build: m1 wins, m1_lock = 1, m0_req held high -> m0 is not granted while lock is high; m0 is granted the IDLE cycle after lock drops.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and SETUP/ACCESS/DONE sequencer for the shared ROM/RAM bus.
// Optional loader bus lock: define MEM_BUS_ARBITER_LOCK_EN to add the m1_lock input.
`timescale 1ns/1ps

module mem_bus_arbiter #(
    parameter int AW          = 13,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int FIXED_PRI   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
`ifdef MEM_BUS_ARBITER_LOCK_EN
    input  logic          m1_lock,
`endif
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          wr,
    output logic [DW-1:0] bus_dout,
    output logic          bus_oe,
    input  logic [DW-1:0] bus_din,
    output logic          owner
);

    // A zero wait count still needs one strobe cycle on the bus.
    localparam logic [3:0] WAIT_EFF_C = (WAIT_CYCLES < 1)  ? 4'd1 :
                                        (WAIT_CYCLES > 15) ? 4'd15 : 4'(WAIT_CYCLES);
    localparam logic [1:0] PRI_C = 2'(FIXED_PRI);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [3:0]      cnt_r;
    logic [3:0]      cnt_s;
    logic            req0_r;
    logic            req1_r;
    logic            we_r;
    logic            lock_s;
    logic            elig0_s;
    logic            elig1_s;
    logic            grant_s;
    logic            grant_valid_s;
    logic            sel_we_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wdata_s;
    logic            we_next_s;
    logic            last_access_s;

    // Arbitration on registered requests and selection of the winner's transaction fields.
    always_comb begin
        lock_s        = 1'b0;
        elig0_s       = 1'b0;
        elig1_s       = 1'b0;
        grant_s       = 1'b0;
        grant_valid_s = 1'b0;
`ifdef MEM_BUS_ARBITER_LOCK_EN
        // The lock only holds once the loader already owns the bus.
        lock_s = owner & m1_lock;
`else
        lock_s = 1'b0;
`endif
        elig0_s       = req0_r & ~lock_s;
        elig1_s       = req1_r;
        grant_valid_s = elig0_s | elig1_s;
        if (elig0_s && elig1_s) begin
            if (PRI_C == 2'd1) begin
                grant_s = 1'b0;
            end else if (PRI_C == 2'd2) begin
                grant_s = 1'b1;
            end else begin
                grant_s = ~owner;
            end
        end else begin
            grant_s = elig1_s;
        end
        sel_we_s    = grant_s ? m1_we    : m0_we;
        sel_addr_s  = grant_s ? m1_addr  : m0_addr;
        sel_wdata_s = grant_s ? m1_wdata : m0_wdata;
        we_next_s   = (state_r == ST_IDLE) ? sel_we_s : we_r;
    end

    // Next-state and wait-counter logic for the bus sequencer.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        last_access_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_ACCESS;
                cnt_s   = 4'd1;
            end
            ST_ACCESS: begin
                if (cnt_r >= WAIT_EFF_C) begin
                    state_s       = ST_DONE;
                    cnt_s         = 4'd0;
                    last_access_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State register plus registered bus strobes, grant latch, acks and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            req0_r   <= 1'b0;
            req1_r   <= 1'b0;
            we_r     <= 1'b0;
            owner    <= 1'b1;
            addr     <= '0;
            bus_dout <= '0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            bus_oe   <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            req0_r  <= m0_req;
            req1_r  <= m1_req;
            if ((state_r == ST_IDLE) && grant_valid_s) begin
                owner    <= grant_s;
                we_r     <= sel_we_s;
                addr     <= sel_addr_s;
                bus_dout <= sel_wdata_s;
            end
            // Strobes are derived from the next state so they line up with it.
            rd     <= (state_s == ST_ACCESS) & ~we_next_s;
            wr     <= (state_s == ST_ACCESS) & we_next_s;
            bus_oe <= ((state_s == ST_SETUP) || (state_s == ST_ACCESS)) & we_next_s;
            m0_ack <= last_access_s & ~owner;
            m1_ack <= last_access_s & owner;
            if (last_access_s && !we_r && !owner) begin
                m0_rdata <= bus_din;
            end
            if (last_access_s && !we_r && owner) begin
                m1_rdata <= bus_din;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table for single transactions plus
// hand-written sequences for reset abort, contention, latching and (optionally) lock.
`timescale 1ns/1ps

module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [12:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [7:0]  m0_rdata, m1_rdata;
    logic [12:0] addr;
    logic        rd, wr, bus_oe, owner;
    logic [7:0]  bus_dout, bus_din;
`ifdef MEM_BUS_ARBITER_LOCK_EN
    logic        m1_lock;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
`ifdef MEM_BUS_ARBITER_LOCK_EN
        .m1_lock(m1_lock),
`endif
        .addr(addr), .rd(rd), .wr(wr), .bus_dout(bus_dout), .bus_oe(bus_oe),
        .bus_din(bus_din), .owner(owner)
    );

    typedef struct {
        logic        m;
        logic        we;
        logic [12:0] a;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic m, input logic req, input logic we,
                           input logic [12:0] a, input logic [7:0] d);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    // One isolated transaction, checked cycle by cycle against the expected bus timing.
    task automatic run_vec(input vec_t v);
        set_req(v.m, 1'b1, v.we, v.a, v.wdata);
        bus_din = v.din;
        tick;
        chk("idle_strobes", 32'({rd, wr, m0_ack, m1_ack}), 32'd0);
        tick;
        chk("setup_addr", 32'(addr), 32'(v.a));
        chk("setup_rdwr", 32'({rd, wr}), 32'd0);
        chk("setup_oe", 32'(bus_oe), 32'(v.we));
        chk("setup_owner", 32'(owner), 32'(v.m));
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("access_rd", 32'(rd), 32'(!v.we));
            chk("access_wr", 32'(wr), 32'(v.we));
            chk("access_oe", 32'(bus_oe), 32'(v.we));
            chk("access_addr", 32'(addr), 32'(v.a));
            if (v.we) chk("access_dout", 32'(bus_dout), 32'(v.wdata));
        end
        tick;
        chk("done_ack", 32'(v.m ? m1_ack : m0_ack), 32'd1);
        chk("done_other_ack", 32'(v.m ? m0_ack : m1_ack), 32'd0);
        chk("done_rdata", 32'(v.m ? m1_rdata : m0_rdata), 32'(v.exp_rdata));
        chk("done_strobes", 32'({rd, wr, bus_oe}), 32'd0);
        set_req(v.m, 1'b0, v.we, v.a, v.wdata);
        tick;
        chk("ack_pulse_width", 32'({m0_ack, m1_ack}), 32'd0);
        chk("idle_addr_hold", 32'(addr), 32'(v.a));
    endtask

    initial begin
        int   n_ack;
        int   ack_cyc[4];
        logic ack_who[4];

        vecs[0] = '{1'b0, 1'b0, 13'h1FFE, 8'h00, 8'hA5, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 13'h0042, 8'h3C, 8'h00, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 13'h0042, 8'h00, 8'h3C, 8'h3C};
        vecs[3] = '{1'b0, 1'b1, 13'h0005, 8'h77, 8'h11, 8'hA5};
        vecs[4] = '{1'b1, 1'b0, 13'h0000, 8'h00, 8'hFF, 8'hFF};
        vecs[5] = '{1'b0, 1'b0, 13'h1000, 8'h00, 8'h00, 8'h00};

        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 13'h0000, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 13'h0000, 8'h00);
        bus_din = 8'h00;
`ifdef MEM_BUS_ARBITER_LOCK_EN
        m1_lock = 1'b0;
`endif
        tick;
        tick;
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_strobes", 32'({rd, wr, bus_oe}), 32'd0);
        chk("rst_dout", 32'(bus_dout), 32'd0);
        chk("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
        chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
        chk("rst_owner", 32'(owner), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Address change during ACCESS and req dropped in SETUP.
        set_req(1'b0, 1'b1, 1'b0, 13'h0010, 8'h00);
        bus_din = 8'h66;
        tick;
        tick;
        m0_req = 1'b0;
        tick;
        m0_addr = 13'h0020;
        tick;
        chk("latch_addr", 32'(addr), 32'h0010);
        tick;
        chk("latch_ack", 32'(m0_ack), 32'd1);
        chk("latch_rdata", 32'(m0_rdata), 32'h66);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("latch_no_retrigger", 32'({rd, m0_ack, m1_ack}), 32'd0);
        end

        // Reset in the middle of an ACCESS phase of an m0 write.
        set_req(1'b0, 1'b1, 1'b1, 13'h0123, 8'h99);
        tick;
        tick;
        tick;
        chk("pre_rst_wr", 32'(wr), 32'd1);
        rst = 1'b1;
        m0_req = 1'b0;
        tick;
        rst = 1'b0;
        chk("midrst_addr", 32'(addr), 32'd0);
        chk("midrst_strobes", 32'({rd, wr, bus_oe}), 32'd0);
        chk("midrst_dout", 32'(bus_dout), 32'd0);
        chk("midrst_owner", 32'(owner), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("midrst_no_ack", 32'({m0_ack, m1_ack, wr}), 32'd0);
        end

        // Continuous contention: expect m0, m1, m0, m1 with 5-cycle spacing.
        n_ack = 0;
        set_req(1'b0, 1'b1, 1'b0, 13'h0011, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 13'h0022, 8'h00);
        bus_din = 8'h5A;
        for (int c = 1; c <= 30; c++) begin
            tick;
            if (rd && wr) chk("rr_rd_wr_exclusive", 32'({rd, wr}), 32'd0);
            if (m0_ack || m1_ack) begin
                if (m0_ack && m1_ack) chk("rr_single_ack", 32'({m0_ack, m1_ack}), 32'b01);
                if (n_ack < 4) begin
                    ack_cyc[n_ack] = c;
                    ack_who[n_ack] = m1_ack;
                end
                n_ack++;
                if (n_ack == 4) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end
        end
        chk("rr_ack_count", 32'(n_ack), 32'd4);
        if (n_ack >= 4) begin
            chk("rr_grant0", 32'(ack_who[0]), 32'd0);
            chk("rr_grant1", 32'(ack_who[1]), 32'd1);
            chk("rr_grant2", 32'(ack_who[2]), 32'd0);
            chk("rr_grant3", 32'(ack_who[3]), 32'd1);
            chk("rr_first_latency", 32'(ack_cyc[0]), 32'd5);
            for (int i = 1; i < 4; i++) chk("rr_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
        end

`ifdef MEM_BUS_ARBITER_LOCK_EN
        // Loader takes the bus, then locks it against a waiting CPU.
        run_vec('{1'b1, 1'b1, 13'h0100, 8'hC3, 8'h00, 8'h5A});
        m1_lock = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 13'h0200, 8'h00);
        bus_din = 8'h81;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("lock_blocks_m0", 32'({rd, m0_ack, owner}), 32'd1);
        end
        m1_lock = 1'b0;
        n_ack = 0;
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (m0_ack && n_ack == 0) n_ack = c;
        end
        chk("unlock_grant_latency", 32'(n_ack), 32'd4);
        chk("unlock_rdata", 32'(m0_rdata), 32'h81);
        m0_req = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
